create_kernel: RTL and testbench

- Sequential generator of a square 2-D Gaussian convolution kernel with 8-bit unsigned weights.
- The kernel has odd size n (1..MAX_KERNAL) and integer sigma (1..7).
- It feeds the Gaussian blur stage of the FAST-corner ISP pipeline.
- One coefficient is computed per clock using a 1-D Gaussian ROM and a single 8x8 multiplier; `done` pulses when the full n x n block is valid.

---
 rtl/create_kernel.sv | 122 ++++++++++++
 tb/tb_create_kernel.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/create_kernel.sv
// Sequential 2-D Gaussian kernel generator: one 8-bit coefficient per clock,
// built from a 1-D Gaussian ROM and a single 8x8 multiply, normalised by ~/255.
module create_kernel #(
  parameter  int MAX_KERNAL = 7,
  localparam int KW         = (MAX_KERNAL > 1) ? $clog2(MAX_KERNAL) : 1
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic [2:0]                               sigma,
  input  logic                                     start,
  input  logic [KW-1:0]                            kernel_size,
  output logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel,
  output logic                                     err,
  output logic                                     done,
  output logic [1:0]                               dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_t;

  state_t                                    r_state;
  logic [2:0]                                r_sigma;
  logic [KW-1:0]                             r_n;
  logic [KW-1:0]                             r_row;
  logic [KW-1:0]                             r_col;
  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] r_kernel;
  logic                                      r_err;
  logic                                      r_done;

  logic          w_legal;
  logic [KW-1:0] w_c;
  logic [1:0]    w_dx;
  logic [1:0]    w_dy;
  logic [7:0]    w_gx;
  logic [7:0]    w_gy;
  logic [15:0]   w_prod;
  logic [15:0]   w_sum;
  logic [7:0]    w_coef;
  logic          w_last;

  // round(255*exp(-d^2/(2*s^2))) for s = 1..7, d = 0..3
  function automatic logic [7:0] g_rom(input logic [2:0] s, input logic [1:0] d);
    logic [7:0] v;
    v = 8'd255;
    case ({s, d})
      5'b001_01: v = 8'd155;  5'b001_10: v = 8'd35;   5'b001_11: v = 8'd3;
      5'b010_01: v = 8'd225;  5'b010_10: v = 8'd155;  5'b010_11: v = 8'd83;
      5'b011_01: v = 8'd241;  5'b011_10: v = 8'd204;  5'b011_11: v = 8'd155;
      5'b100_01: v = 8'd247;  5'b100_10: v = 8'd225;  5'b100_11: v = 8'd192;
      5'b101_01: v = 8'd250;  5'b101_10: v = 8'd235;  5'b101_11: v = 8'd213;
      5'b110_01: v = 8'd251;  5'b110_10: v = 8'd241;  5'b110_11: v = 8'd225;
      5'b111_01: v = 8'd252;  5'b111_10: v = 8'd245;  5'b111_11: v = 8'd233;
      default:   v = 8'd255;
    endcase
    return v;
  endfunction

  assign w_legal = (sigma != 3'd0) && kernel_size[0] && (kernel_size <= KW'(MAX_KERNAL));
  assign w_c     = r_n >> 1;
  assign w_dx    = 2'((r_col >= w_c) ? (r_col - w_c) : (w_c - r_col));
  assign w_dy    = 2'((r_row >= w_c) ? (r_row - w_c) : (w_c - r_row));
  assign w_gx    = g_rom(r_sigma, w_dx);
  assign w_gy    = g_rom(r_sigma, w_dy);
  assign w_prod  = w_gx * w_gy;
  // p + p/256 + 128 peaks at 65407, so 16 bits never overflow
  assign w_sum   = w_prod + (w_prod >> 8) + 16'd128;
  assign w_coef  = 8'(w_sum >> 8);
  assign w_last  = (r_row == r_n - KW'(1)) && (r_col == r_n - KW'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_sigma  <= 3'd0;
      r_n      <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_kernel <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_sigma  <= sigma;
              r_n      <= kernel_size;
              r_kernel <= '0;
              r_err    <= 1'b0;
              r_row    <= '0;
              r_col    <= '0;
              r_state  <= S_CALC;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_kernel[r_row][r_col] <= w_coef;
          if (w_last) begin
            r_state <= S_FIN;
          end else if (r_col == r_n - KW'(1)) begin
            r_col <= '0;
            r_row <= r_row + KW'(1);
          end else begin
            r_col <= r_col + KW'(1);
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign kernel    = r_kernel;
  assign err       = r_err;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_create_kernel.sv
// Directed, table-driven bench for create_kernel: build latency, done pulse
// count, hand-computed coefficients, illegal requests and mid-build reset.
module tb_create_kernel;
  localparam int MK = 7;

  logic                       clk = 1'b0;
  logic                       n_rst = 1'b0;
  logic                       start = 1'b0;
  logic [2:0]                 sigma = 3'd1;
  logic [2:0]                 kernel_size = 3'd1;
  logic [MK-1:0][MK-1:0][7:0] kernel;
  logic                       err;
  logic                       done;
  logic [1:0]                 dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  create_kernel #(.MAX_KERNAL(MK)) dut (
    .clk(clk), .n_rst(n_rst), .sigma(sigma), .start(start),
    .kernel_size(kernel_size), .kernel(kernel), .err(err), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int n; int lat; } build_t;
  typedef struct { int bld; int r; int c; int exp; } probe_t;

  build_t builds[5] = '{'{2, 3, 10}, '{1, 3, 10}, '{1, 7, 50}, '{7, 5, 26}, '{3, 1, 2}};
  probe_t probes[28] = '{
    '{0, 0, 0, 199}, '{0, 0, 1, 225}, '{0, 1, 1, 255}, '{0, 2, 2, 199}, '{0, 1, 0, 225}, '{0, 3, 3, 0},
    '{1, 0, 0, 94},  '{1, 0, 1, 155}, '{1, 1, 1, 255}, '{1, 2, 0, 94},
    '{2, 0, 0, 0},   '{2, 3, 0, 3},   '{2, 3, 3, 255}, '{2, 0, 3, 3},   '{2, 1, 1, 5},
    '{2, 2, 2, 94},  '{2, 3, 1, 35},  '{2, 6, 6, 0},
    '{3, 0, 0, 235}, '{3, 1, 1, 249}, '{3, 0, 2, 245}, '{3, 2, 2, 255}, '{3, 0, 1, 242},
    '{3, 5, 0, 0},   '{3, 4, 5, 0},
    '{4, 0, 0, 255}, '{4, 0, 1, 0},   '{4, 1, 0, 0}
  };

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int g_of(input int s, input int d);
    int t[7][4] = '{'{255, 155, 35, 3},   '{255, 225, 155, 83},  '{255, 241, 204, 155},
                    '{255, 247, 225, 192}, '{255, 250, 235, 213}, '{255, 251, 241, 225},
                    '{255, 252, 245, 233}};
    return t[s-1][d];
  endfunction

  function automatic int model(input int s, input int n, input int r, input int c);
    int cc, dx, dy, p;
    if (r >= n || c >= n) return 0;
    cc = (n - 1) / 2;
    dx = (c >= cc) ? c - cc : cc - c;
    dy = (r >= cc) ? r - cc : cc - r;
    p  = g_of(s, dx) * g_of(s, dy);
    return (p + (p >> 8) + 128) >> 8;
  endfunction

  task automatic check_full(input string nm, input int s, input int n);
    int bad = 0;
    for (int r = 0; r < MK; r++)
      for (int c = 0; c < MK; c++)
        if (int'(kernel[r][c]) != model(s, n, r, c)) bad++;
    check(nm, bad, 0);
  endtask

  // Start pulse on the next edge; lat counts edges after that start edge.
  task automatic run_build(input int s, input int n, input bit perturb,
                           output int lat, output int pulses);
    @(negedge clk);
    sigma = 3'(s); kernel_size = 3'(n); start = 1'b1;
    lat = -1; pulses = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (perturb && j == 3) begin sigma = 3'd7; kernel_size = 3'd5; start = 1'b1; end
      if (perturb && j == 4) start = 1'b0;
      if (done) begin
        pulses++;
        if (lat < 0) lat = j;
      end
    end
  endtask

  task automatic try_illegal(input string nm, input int s, input int n);
    logic [MK-1:0][MK-1:0][7:0] snap;
    int pulses = 0;
    snap = kernel;
    @(negedge clk);
    sigma = 3'(s); kernel_size = 3'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({nm, "_err"}, int'(err), 1);
    check({nm, "_no_done"}, pulses, 0);
    check({nm, "_kernel_kept"}, int'(kernel === snap), 1);
    check({nm, "_idle"}, int'(dbg_state), 0);
  endtask

  initial begin
    int lat, pulses;
    repeat (3) @(negedge clk);
    check("rst_kernel", int'(kernel === '0), 1);
    check("rst_err", int'(err), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), 0);
    n_rst = 1'b1;

    for (int b = 0; b < 5; b++) begin
      exp_q.push_back(8'(builds[b].lat));
      run_build(builds[b].s, builds[b].n, 1'b0, lat, pulses);
      check($sformatf("b%0d_latency", b), lat, int'(exp_q.pop_front()));
      check($sformatf("b%0d_pulses", b), pulses, 1);
      check($sformatf("b%0d_err", b), int'(err), 0);
      for (int i = 0; i < 28; i++) begin
        if (probes[i].bld == b) begin
          exp_q.push_back(8'(probes[i].exp));
          check($sformatf("b%0d_k%0d%0d", b, probes[i].r, probes[i].c),
                int'(kernel[probes[i].r][probes[i].c]), int'(exp_q.pop_front()));
        end
      end
      check_full($sformatf("b%0d_full", b), builds[b].s, builds[b].n);
    end

    try_illegal("sigma0", 0, 3);
    try_illegal("n4", 2, 4);
    try_illegal("n0", 2, 0);
    run_build(2, 3, 1'b0, lat, pulses);
    check("legal_after_illegal_err", int'(err), 0);
    check("legal_after_illegal_lat", lat, 10);

    run_build(1, 3, 1'b1, lat, pulses);
    check("perturb_latency", lat, 10);
    check("perturb_pulses", pulses, 1);
    check_full("perturb_full", 1, 3);

    @(negedge clk);
    sigma = 3'd1; kernel_size = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("midcalc_state", int'(dbg_state), 1);
    check("midcalc_partial", int'(kernel[0][3]), 3);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_kernel", int'(kernel === '0), 1);
    check("async_rst_done", int'(done), 0);
    check("async_rst_err", int'(err), 0);
    check("async_rst_state", int'(dbg_state), 0);
    @(negedge clk);
    n_rst = 1'b1;
    run_build(2, 3, 1'b0, lat, pulses);
    check("post_rst_latency", lat, 10);
    check("post_rst_pulses", pulses, 1);
    check("post_rst_k00", int'(kernel[0][0]), 199);
    check_full("post_rst_full", 2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
